// File: rtl/skew_feed_array.sv
// Multi-lane operand shift bank for the systolic array edge: parallel/serial fill,
// then a diagonally skewed head-first stream with optional tail recirculation.
module skew_feed_array #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CHANNELS   = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [1:0]                                     ctrl_code,
    input  logic                                           recirc,
    input  logic [0:CHANNELS-1]                            wr_mask,
    input  logic [0:CHANNELS-1][0:DEPTH-1][DATA_WIDTH-1:0] data_in,
    input  logic [0:CHANNELS-1][DATA_WIDTH-1:0]            data_write,
    output logic [0:CHANNELS-1][DATA_WIDTH-1:0]            data_out,
    output logic [0:CHANNELS-1]                            out_valid,
    output logic                                           busy,
    output logic                                           done
);
    localparam int L  = DEPTH + CHANNELS - 1;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
    typedef logic [0:CHANNELS-1][0:DEPTH-1][DATA_WIDTH-1:0] mem_t;

    state_t                              state_q;
    logic [CW-1:0]                       cnt_q;
    logic                                recirc_q;
    mem_t                                mem_q, mem_d;
    logic [0:CHANNELS-1][DATA_WIDTH-1:0] dout_q, dout_d;
    logic [0:CHANNELS-1]                 vld_q, vld_d;
    logic                                done_q;
    logic                                last_w;

    assign last_w = (cnt_q == CW'(L - 1));

    always_comb begin
        mem_d  = mem_q;
        dout_d = '0;
        vld_d  = '0;
        if (state_q == IDLE) begin
            if (ctrl_code == 2'b01) begin
                mem_d = data_in;
            end else if (ctrl_code == 2'b10) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (wr_mask[c]) begin
                        for (int i = 0; i < DEPTH - 1; i++) mem_d[c][i] = mem_q[c][i+1];
                        mem_d[c][DEPTH-1] = data_write[c];
                    end
                end
            end
        end else begin
            // Lane c is live during counts c .. c+DEPTH-1, which produces the diagonal skew.
            for (int c = 0; c < CHANNELS; c++) begin
                if ((c <= int'(cnt_q)) && (int'(cnt_q) < c + DEPTH)) begin
                    dout_d[c] = mem_q[c][0];
                    vld_d[c]  = 1'b1;
                    for (int i = 0; i < DEPTH - 1; i++) mem_d[c][i] = mem_q[c][i+1];
                    mem_d[c][DEPTH-1] = recirc_q ? mem_q[c][0] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            recirc_q <= 1'b0;
            mem_q    <= '0;
            dout_q   <= '0;
            vld_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (ctrl_code == 2'b11) begin
                    state_q  <= STREAM;
                    cnt_q    <= '0;
                    recirc_q <= recirc;
                end
            end else begin
                if (last_w) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign data_out  = dout_q;
    assign out_valid = vld_q;
    assign busy      = (state_q == STREAM);
    assign done      = done_q;
endmodule
